// File: rtl/gate_actuator.sv
// Purpose : responder for the open/close command link; drives one lock gate through
//           timed travel and enforces the water-level interlock on opening.
// Latency : a request seen in cycle n moves the gate from n+1; full stroke TRAVEL_CYCLES.
// Backpressure: none; requests are edge events and are accepted or refused on arrival.
//
// Ports:
//   Clock      - system clock, all state on posedge
//   Reset      - synchronous, active-low reset (snaps the gate to CLOSED)
//   OpenClose  - toggle request; each rising edge is one request
//   Interlock  - 1 = water levels unequal, opening forbidden (closing always allowed)
//   GateOpen   - registered, gate fully open
//   GateClosed - registered, gate fully closed
//   GateMoving - registered, gate travelling in either direction
//   Busy       - registered, same as GateMoving (controller EVState)
//   Rejected   - registered one-cycle pulse, an open request was refused
//
// Optional feature: define AUTO_CLOSE_EN to close the gate automatically after it
// has been fully open for OPEN_TIMEOUT cycles.

module gate_actuator #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int CNT_W         = 4,
    parameter int OPEN_TIMEOUT  = 12
) (
    input  logic Clock,
    input  logic Reset,
    input  logic OpenClose,
    input  logic Interlock,
    output logic GateOpen,
    output logic GateClosed,
    output logic GateMoving,
    output logic Busy,
    output logic Rejected
);

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TRAV_MAX = CNT_W'(TRAVEL_CYCLES - 1);
    // Loaded on entry to OPEN. Without AUTO_CLOSE_EN the counter is not looked at
    // while OPEN, so the loaded value is a don't-care there.
    localparam logic [CNT_W-1:0] OPEN_MAX = CNT_W'(OPEN_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             oc_q;
    logic             rej_q, rej_d;
    logic             open_q, closed_q, moving_q;
    logic             req;

    // One request per rising edge of OpenClose, however long it is held.
    assign req = OpenClose & ~oc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rej_d   = 1'b0;
        unique case (state_q)
            ST_CLOSED: begin
                if (req) begin
                    if (Interlock) begin
                        rej_d = 1'b1;
                    end else begin
                        state_d = ST_OPENING;
                        cnt_d   = TRAV_MAX;
                    end
                end
            end
            ST_OPENING: begin
                // Interlock abort and a user reversal share the same path: the
                // mirrored count makes the return trip as long as the travel so far.
                if (Interlock || req) begin
                    state_d = ST_CLOSING;
                    cnt_d   = TRAV_MAX - cnt_q;
                end else if (cnt_q == '0) begin
                    state_d = ST_OPEN;
                    cnt_d   = OPEN_MAX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_OPEN: begin
                if (req) begin
                    state_d = ST_CLOSING;
                    cnt_d   = TRAV_MAX;
                end
`ifdef AUTO_CLOSE_EN
                else if (cnt_q == '0) begin
                    state_d = ST_CLOSING;
                    cnt_d   = TRAV_MAX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            ST_CLOSING: begin
                if (req && !Interlock) begin
                    state_d = ST_OPENING;
                    cnt_d   = TRAV_MAX - cnt_q;
                end else begin
                    // A refused reopen does not disturb the closing schedule.
                    rej_d = req;
                    if (cnt_q == '0) begin
                        state_d = ST_CLOSED;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_CLOSED;
                cnt_d   = '0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= ST_CLOSED;
            cnt_q    <= '0;
            oc_q     <= 1'b0;
            rej_q    <= 1'b0;
            open_q   <= 1'b0;
            closed_q <= 1'b1;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            oc_q     <= OpenClose;
            rej_q    <= rej_d;
            open_q   <= (state_d == ST_OPEN);
            closed_q <= (state_d == ST_CLOSED);
            moving_q <= (state_d == ST_OPENING) || (state_d == ST_CLOSING);
        end
    end

    assign GateOpen   = open_q;
    assign GateClosed = closed_q;
    assign GateMoving = moving_q;
    assign Busy       = moving_q;
    assign Rejected   = rej_q;

endmodule

// File: tb/tb_gate_actuator.sv
module tb_gate_actuator;

    localparam int T  = 8;
    localparam int TO = 12;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic OpenClose = 1'b0;
    logic Interlock = 1'b0;
    logic GateOpen, GateClosed, GateMoving, Busy, Rejected;

    gate_actuator #(.TRAVEL_CYCLES(T), .CNT_W(4), .OPEN_TIMEOUT(TO)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .OpenClose  (OpenClose),
        .Interlock  (Interlock),
        .GateOpen   (GateOpen),
        .GateClosed (GateClosed),
        .GateMoving (GateMoving),
        .Busy       (Busy),
        .Rejected   (Rejected)
    );

    always #5 Clock = ~Clock;

    // Expected {open, closed, moving, busy, rejected} after each clock edge.
    logic [4:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model: the gate has a physical position 0..T-1 (0 = just off the
    // closed stop). Opening walks it up, closing walks it down, a reversal keeps the
    // position where it is. OPEN is reached after position T-1 while opening, CLOSED
    // after position 0 while closing.
    int m_mode;   // 0 closed, 1 opening, 2 open, 3 closing
    int m_pos;
    int m_open_left;
    bit m_prev;
    bit m_rej;

    task automatic model(input bit rst, input bit oc, input bit il);
        bit req;
        if (!rst) begin
            m_mode = 0; m_pos = 0; m_prev = 1'b0; m_rej = 1'b0; m_open_left = 0;
        end else begin
            req    = oc && !m_prev;
            m_prev = oc;
            m_rej  = 1'b0;
            case (m_mode)
                0: if (req) begin
                    if (il) m_rej = 1'b1;
                    else begin m_mode = 1; m_pos = 0; end
                end
                1: if (il || req) m_mode = 3;
                   else if (m_pos == T - 1) begin m_mode = 2; m_open_left = TO; end
                   else m_pos++;
                2: begin
                    if (req) begin m_mode = 3; m_pos = T - 1; end
`ifdef AUTO_CLOSE_EN
                    else begin
                        m_open_left--;
                        if (m_open_left == 0) begin m_mode = 3; m_pos = T - 1; end
                    end
`endif
                end
                default: if (req && !il) m_mode = 1;
                   else begin
                       if (req) m_rej = 1'b1;
                       if (m_pos == 0) m_mode = 0;
                       else m_pos--;
                   end
            endcase
        end
    endtask

    task automatic step(input bit rst, input bit oc, input bit il);
        bit mv;
        @(negedge Clock);
        Reset = rst; OpenClose = oc; Interlock = il;
        model(rst, oc, il);
        mv = (m_mode == 1) || (m_mode == 3);
        exp_q.push_back({m_mode == 2, m_mode == 0, mv, mv, m_rej});
    endtask

    task automatic hold(input int n, input bit oc, input bit il);
        for (int i = 0; i < n; i++) step(1'b1, oc, il);
    endtask

    // Monitor: compares whatever the DUT shows after each edge with the oldest prediction.
    initial begin
        logic [4:0] e, a;
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {GateOpen, GateClosed, GateMoving, Busy, Rejected};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t open/closed/moving/busy/rej got %b want %b",
                             $time, a, e);
                end
            end
        end
    end

    initial begin
        bit oc, il, rst;
        // Reset with OpenClose already high; release yields exactly one request.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        hold(20, 1'b1, 1'b0);
        // Second edge closes.
        hold(3, 1'b0, 1'b0);
        hold(12, 1'b1, 1'b0);
        // Open request refused by interlock.
        hold(2, 1'b0, 1'b1);
        hold(1, 1'b1, 1'b1);
        hold(3, 1'b0, 1'b1);
        hold(2, 1'b0, 1'b0);
        // Interlock rises after 3 cycles of travel.
        hold(1, 1'b1, 1'b0);
        hold(2, 1'b0, 1'b0);
        hold(1, 1'b0, 1'b1);
        hold(10, 1'b0, 1'b0);
        // User reversal after 5 cycles, then a refused reopen while closing.
        hold(1, 1'b1, 1'b0);
        hold(4, 1'b0, 1'b0);
        hold(1, 1'b1, 1'b0);
        hold(1, 1'b0, 1'b1);
        hold(1, 1'b1, 1'b1);
        hold(10, 1'b0, 1'b0);
        // Fully open and left alone for a long time.
        hold(1, 1'b1, 1'b0);
        hold(110, 1'b0, 1'b0);
        hold(1, 1'b1, 1'b0);
        hold(12, 1'b0, 1'b0);
        // Randomised traffic, including the occasional reset mid-stroke.
        oc = 1'b0; il = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0)  oc = ~oc;
            if ($urandom_range(15) == 0) il = ~il;
            rst = ($urandom_range(199) != 0);
            step(rst, oc, il);
        end
        @(posedge Clock);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
